cdb_broadcaster: RTL and testbench
==================================

Name: cdb_broadcaster

Overview:
Transmit end of the common data bus. It collects completions from the five functional-unit slots (ALU, LOAD, STORE, MULT0, MULT1) and buffers one completion per slot. Each cycle it round-robin arbitrates a single CDB broadcast of tag and value to the reservation station and other tag listeners. It also pulses the per-slot free vector so the reservation station can release the corresponding entry.

Parameters:
NUM_SRC, 5, number of FU completion sources; index equals the reservation-station slot index (0 ALU, 1 LOAD, 2 STORE, 3 MULT0, 4 MULT1)
XLEN, 32, result value width in bits

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
fu_done  input  NUM_SRC  per-source completion valid
fu_tag  input  NUM_SRC x $bits(REG)  per-source destination physical register (REG)
fu_value  input  NUM_SRC x XLEN  per-source result value
fu_has_dest  input  NUM_SRC  1 means the completion writes a register; 0 (e.g. store) means free only, no broadcast
fu_ready  output  NUM_SRC  per-source handshake: buffer can accept this cycle
flush  input  1  synchronous squash of all buffered completions
cdb_ready  output  1  broadcast valid (registered)
cdb_tag  output  $bits(REG)  broadcast tag; .num is the register, .ready is 1 whenever cdb_ready is 1
cdb_value  output  XLEN  broadcast value
free  output  NUM_SRC  one-cycle pulse per slot whose completion retired (registered)

Behaviour:
- Reset (reset==0, async): all buffer valids are 0 and rr_ptr is 0. cdb_ready, cdb_tag, cdb_value and free are all 0. fu_ready is all 1 once reset deasserts.
- Per-source one-entry buffer: buf_valid, buf_tag, buf_value, buf_dest.
- Handshake: fu_ready[i] = !buf_valid[i] || drain[i] (combinational). A transfer happens when fu_done[i] && fu_ready[i] at a clock edge.
- fu_done[i] while fu_ready[i]==0 is a protocol violation: the input is ignored and a simulation assertion fires.
- Drain condition, evaluated combinationally on the buffers:
  - A buffered entry with buf_dest==0 drains every cycle it is valid.
  - Among valid entries with buf_dest==1, exactly one is granted.
  - Grant priority is round-robin starting at rr_ptr and wrapping modulo NUM_SRC.
- Grant side effects, at the next edge:
  - cdb_ready<=1, cdb_tag.num<=buf_tag.num, cdb_tag.ready<=1, cdb_value<=buf_value.
  - rr_ptr<=(grant+1) mod NUM_SRC.
- No grant: cdb_ready<=0, cdb_tag/cdb_value hold their previous values, rr_ptr holds.
- free[i]<=drain[i] at the next edge. Multiple free bits may be high in one cycle: at most one from a broadcast plus any number from no-dest retirements.
- Latency:
  - fu_done at cycle t into an empty buffer makes the entry visible in cycle t+1.
  - If granted in t+1, cdb_ready/free are high in cycle t+2.
  - The minimum completion-to-broadcast latency is therefore 2 cycles.
  - Sustained throughput: one broadcast per cycle.
- Simultaneous drain and refill of the same slot: the new entry is captured and the old one retires. No bubble on fu_ready.
- Starvation bound: a waiting has_dest entry is granted within NUM_SRC cycles.
- flush==1:
  - All buf_valid<=0 at the edge, and any same-cycle fu_done is discarded.
  - cdb_ready<=0 and free<=0 for that edge.
  - rr_ptr holds.
  - flush has priority over grants.
- Reset mid-operation: buffered completions are lost and outputs drop to 0 immediately, without waiting for a clock edge.

Decomposition:
- Shared package:
  - REG typedef, with fields num and ready.
  - FU_FUNC enum (FU_ALU, FU_LOAD, FU_STORE, FU_MULT).
  - CDB_PACKET struct {tag, value}.
  - Constants NUM_SRC=5 and XLEN=32.
  - Slot index constants SLOT_ALU=0, SLOT_LOAD=1, SLOT_STORE=2, SLOT_MULT0=3, SLOT_MULT1=4.
- Sub-module rr_arbiter (NUM_SRC-wide request vector, rr_ptr input, one-hot grant and grant-index output). It is purely combinational; the pointer register lives in cdb_broadcaster.

Test Plan:
- Single completion: release reset, then fu_done[0]=1, fu_tag.num=7, fu_value=32'hDEAD_BEEF for 1 cycle at t. Required: cdb_ready=1, cdb_tag.num=7, cdb_tag.ready=1, cdb_value=32'hDEADBEEF, free=5'b00001 in cycle t+2, then cdb_ready=0 and free=0.
- Contention/round-robin: slots 0, 3, 4 complete in the same cycle (tags 3, 9, 12) with rr_ptr=0. Required: broadcasts 3, 9, 12 on three consecutive cycles, free bits 0, 3, 4 in matching order, rr_ptr ending at 0.
- Store without dest plus ALU: slot 2 (has_dest=0) and slot 0 (tag 5) complete together. Required: in one cycle, cdb_ready=1, tag 5, free=5'b00101. No broadcast ever carries slot 2's tag.
- Backpressure: hold slots 0 and 1 both valid and fire slot 1 again the cycle it is not granted. Required: fu_ready[1]=0 that cycle. After its grant, fu_ready[1]=1 in the same cycle and the new entry is captured; no entry is lost or duplicated.
- Flush: three entries buffered, flush=1 for 1 cycle. Required: next cycle cdb_ready=0 and free=0, all fu_ready=1, and no stale broadcast follows.
- Async reset: assert reset=0 mid-cycle while cdb_ready=1. Required: cdb_ready, free and cdb_tag read 0 before the next clock edge, and buffers stay empty after reset is released.

Source files
------------

// File: rtl/cdb_broadcaster_pkg.sv
// Shared types and constants for the CDB transmit side.
// Latency: n/a (types only).
// Backpressure: n/a.
package cdb_broadcaster_pkg;

  localparam int NUM_SRC = 5;
  localparam int XLEN    = 32;
  localparam int PREG_W  = 6;
  localparam int PTR_W   = $clog2(NUM_SRC);

  // Slot index == reservation-station slot index
  localparam int SLOT_ALU   = 0;
  localparam int SLOT_LOAD  = 1;
  localparam int SLOT_STORE = 2;
  localparam int SLOT_MULT0 = 3;
  localparam int SLOT_MULT1 = 4;

  typedef struct packed {
    logic [PREG_W-1:0] num;
    logic              ready;
  } REG;

  typedef enum logic [1:0] {
    FU_ALU   = 2'd0,
    FU_LOAD  = 2'd1,
    FU_STORE = 2'd2,
    FU_MULT  = 2'd3
  } FU_FUNC;

  typedef struct packed {
    REG              tag;
    logic [XLEN-1:0] value;
  } CDB_PACKET;

  // Functional-unit kind behind a given completion slot
  function automatic FU_FUNC slot_func(input int slot);
    case (slot)
      SLOT_ALU:   return FU_ALU;
      SLOT_LOAD:  return FU_LOAD;
      SLOT_STORE: return FU_STORE;
      default:    return FU_MULT;
    endcase
  endfunction

endpackage

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// Round-robin one-of-N picker, search starts at ptr_i and wraps modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller owns the pointer register.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_idx_o,
  output logic          grant_vld_o
);

  localparam logic [PW:0] N_EXT = (PW+1)'(N);

  logic [PW:0]   cand_ext;
  logic [PW-1:0] cand;

  // Walk the requests from ptr_i upward, wrapping, and keep the first hit
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand_ext    = '0;
    cand        = '0;
    for (int off = 0; off < N; off++) begin
      cand_ext = {1'b0, ptr_i} + (PW+1)'(off);
      if (cand_ext >= N_EXT) cand_ext = cand_ext - N_EXT;
      cand = cand_ext[PW-1:0];
      if (!grant_vld_o && req_i[cand]) begin
        grant_vld_o   = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Buffers one completion per FU slot and broadcasts one tag/value per cycle on the CDB.
// Latency: 2 cycles from fu_done to cdb_ready/free (capture edge, then broadcast edge).
// Backpressure: fu_ready[i] drops while slot i holds an entry that is not draining this cycle.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            fu_done,
  input  REG   [NUM_SRC-1:0]            fu_tag,
  input  logic [NUM_SRC-1:0][XLEN-1:0]  fu_value,
  input  logic [NUM_SRC-1:0]            fu_has_dest,
  output logic [NUM_SRC-1:0]            fu_ready,
  input  logic                          flush,
  output logic                          cdb_ready,
  output REG                            cdb_tag,
  output logic [XLEN-1:0]               cdb_value,
  output logic [NUM_SRC-1:0]            free
);

  logic [NUM_SRC-1:0]             buf_valid_q, buf_valid_d;
  logic [NUM_SRC-1:0]             buf_dest_q;
  logic [NUM_SRC-1:0][PREG_W-1:0] buf_tag_q;
  logic [NUM_SRC-1:0][XLEN-1:0]   buf_value_q;
  logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic                           cdb_ready_q;
  CDB_PACKET                      cdb_pkt_q;
  logic [NUM_SRC-1:0]             free_q;

  logic [NUM_SRC-1:0] req, grant, drain, accept;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_vld;

  // Only entries that write a register compete for the bus
  assign req = buf_valid_q & buf_dest_q;

  rr_arbiter #(
    .N  (NUM_SRC),
    .PW (PTR_W)
  ) u_arb (
    .req_i       (req),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  // No-dest entries retire unconditionally; dest entries retire when granted
  assign drain    = (buf_valid_q & ~buf_dest_q) | grant;
  assign fu_ready = ~buf_valid_q | drain;
  assign accept   = fu_done & fu_ready & {NUM_SRC{~flush}};

  // Next buffer occupancy and arbitration pointer; flush wins over everything
  always_comb begin
    buf_valid_d = flush ? '0 : ((buf_valid_q & ~drain) | accept);
    rr_ptr_d    = rr_ptr_q;
    if (!flush && grant_vld) begin
      rr_ptr_d = (grant_idx == PTR_W'(NUM_SRC-1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Buffer capture, broadcast register and free pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_valid_q <= '0;
      buf_dest_q  <= '0;
      buf_tag_q   <= '0;
      buf_value_q <= '0;
      rr_ptr_q    <= '0;
      cdb_ready_q <= 1'b0;
      cdb_pkt_q   <= '0;
      free_q      <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept[i]) begin
          buf_tag_q[i]   <= fu_tag[i].num;
          buf_value_q[i] <= fu_value[i];
          buf_dest_q[i]  <= fu_has_dest[i];
        end
      end
      cdb_ready_q <= grant_vld & ~flush;
      if (grant_vld && !flush) begin
        cdb_pkt_q.tag.num   <= buf_tag_q[grant_idx];
        cdb_pkt_q.tag.ready <= 1'b1;
        cdb_pkt_q.value     <= buf_value_q[grant_idx];
      end
      free_q <= flush ? '0 : drain;
    end
  end

  assign cdb_ready = cdb_ready_q;
  assign cdb_tag   = cdb_pkt_q.tag;
  assign cdb_value = cdb_pkt_q.value;
  assign free      = free_q;

  // A producer must never present a completion to a full, non-draining slot
  a_no_done_when_full: assert property (@(posedge clock) disable iff (!reset)
    ((fu_done & ~fu_ready) == '0))
    else $error("cdb_broadcaster: fu_done while fu_ready low (%b / %b)", fu_done, fu_ready);

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: stimulus queues expected broadcasts,
// a negedge monitor pops and compares whenever the bus or free vector is active.
module tb_cdb_broadcaster;
  import cdb_broadcaster_pkg::*;

  logic                          clock;
  logic                          reset;
  logic [NUM_SRC-1:0]            fu_done;
  REG   [NUM_SRC-1:0]            fu_tag;
  logic [NUM_SRC-1:0][XLEN-1:0]  fu_value;
  logic [NUM_SRC-1:0]            fu_has_dest;
  logic [NUM_SRC-1:0]            fu_ready;
  logic                          flush;
  logic                          cdb_ready;
  REG                            cdb_tag;
  logic [XLEN-1:0]               cdb_value;
  logic [NUM_SRC-1:0]            free;

  cdb_broadcaster dut (
    .clock       (clock),
    .reset       (reset),
    .fu_done     (fu_done),
    .fu_tag      (fu_tag),
    .fu_value    (fu_value),
    .fu_has_dest (fu_has_dest),
    .fu_ready    (fu_ready),
    .flush       (flush),
    .cdb_ready   (cdb_ready),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
    .free        (free)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [PREG_W-1:0]  num;
    logic [XLEN-1:0]    value;
    logic [NUM_SRC-1:0] free;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fire(input int s, input int tag, input logic [XLEN-1:0] val, input logic dest);
    fu_done[s]       = 1'b1;
    fu_tag[s].num    = PREG_W'(tag);
    fu_tag[s].ready  = 1'b0;
    fu_value[s]      = val;
    fu_has_dest[s]   = dest;
  endtask

  task automatic idle();
    fu_done = '0;
  endtask

  task automatic expect_bc(input int tag, input logic [XLEN-1:0] val, input logic [NUM_SRC-1:0] fr);
    exp_t x;
    x.num   = PREG_W'(tag);
    x.value = val;
    x.free  = fr;
    exp_q.push_back(x);
  endtask

  // Monitor: every active bus/free cycle must match the next queued expectation
  always @(negedge clock) begin
    if (reset === 1'b1 && (cdb_ready === 1'b1 || free !== '0)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_output: got ready=%0b tag=%0d value=0x%0h free=%b, required no activity",
                 cdb_ready, cdb_tag.num, cdb_value, free);
      end else begin
        e = exp_q.pop_front();
        check("bc_ready",     64'(cdb_ready),     64'(1'b1));
        check("bc_tag_num",   64'(cdb_tag.num),   64'(e.num));
        check("bc_tag_ready", 64'(cdb_tag.ready), 64'(1'b1));
        check("bc_value",     64'(cdb_value),     64'(e.value));
        check("bc_free",      64'(free),          64'(e.free));
      end
    end
  end

  initial begin
    reset       = 1'b0;
    flush       = 1'b0;
    fu_done     = '0;
    fu_tag      = '0;
    fu_value    = '0;
    fu_has_dest = '0;

    // Reset state
    #12;
    check("rst_cdb_ready", 64'(cdb_ready), 64'(0));
    check("rst_free",      64'(free),      64'(0));
    check("rst_cdb_tag",   64'(cdb_tag),   64'(0));
    check("rst_cdb_value", 64'(cdb_value), 64'(0));
    tick();
    reset = 1'b1;
    check("rst_fu_ready", 64'(fu_ready), 64'(5'b11111));

    // Single completion: broadcast two cycles after fu_done
    fire(0, 7, 32'hDEAD_BEEF, 1'b1);
    expect_bc(7, 32'hDEAD_BEEF, 5'b00001);
    tick(); idle();
    tick();
    tick();
    check("single_after_ready", 64'(cdb_ready), 64'(0));
    check("single_after_free",  64'(free),      64'(0));

    // Re-zero the round-robin pointer
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // Contention: slots 0,3,4 with pointer at 0
    fire(0, 3,  32'h0000_00A0, 1'b1);
    fire(3, 9,  32'h0000_00A3, 1'b1);
    fire(4, 12, 32'h0000_00A4, 1'b1);
    expect_bc(3,  32'h0000_00A0, 5'b00001);
    expect_bc(9,  32'h0000_00A3, 5'b01000);
    expect_bc(12, 32'h0000_00A4, 5'b10000);
    tick(); idle();
    repeat (4) tick();

    // Store without dest retires alongside ALU broadcast; pointer back at 0 picks slot 0 before 4
    fire(2, 30, 32'h5555_5555, 1'b0);
    fire(0, 5,  32'h0000_0055, 1'b1);
    fire(4, 20, 32'h0000_2020, 1'b1);
    expect_bc(5,  32'h0000_0055, 5'b00101);
    expect_bc(20, 32'h0000_2020, 5'b10000);
    tick(); idle();
    repeat (3) tick();

    // Backpressure on slot 1, refill in the cycle it drains
    fire(0, 1, 32'h0000_0011, 1'b1);
    fire(1, 2, 32'h0000_0022, 1'b1);
    expect_bc(1, 32'h0000_0011, 5'b00001);
    expect_bc(2, 32'h0000_0022, 5'b00010);
    expect_bc(4, 32'h0000_0044, 5'b00010);
    tick(); idle();
    check("bp_ready_blocked", 64'(fu_ready), 64'(5'b11101));
    tick();
    check("bp_ready_refill", 64'(fu_ready), 64'(5'b11111));
    fire(1, 4, 32'h0000_0044, 1'b1);
    tick(); idle();
    repeat (3) tick();

    // Flush with three entries buffered; a same-cycle completion is discarded
    fire(0, 40, 32'h0000_0040, 1'b1);
    fire(1, 41, 32'h0000_0041, 1'b1);
    fire(3, 43, 32'h0000_0043, 1'b1);
    tick(); idle();
    flush = 1'b1;
    fire(4, 44, 32'h0000_0044, 1'b1);
    tick(); idle();
    flush = 1'b0;
    check("flush_cdb_ready", 64'(cdb_ready), 64'(0));
    check("flush_free",      64'(free),      64'(0));
    check("flush_fu_ready",  64'(fu_ready),  64'(5'b11111));
    repeat (3) tick();

    // Pointer held at 2 through the flush: slot 3 wins before slot 1
    fire(1, 50, 32'h0000_0050, 1'b1);
    fire(3, 51, 32'h0000_0051, 1'b1);
    expect_bc(51, 32'h0000_0051, 5'b01000);
    expect_bc(50, 32'h0000_0050, 5'b00010);
    tick(); idle();
    repeat (3) tick();

    // Async reset while a broadcast is on the bus and slot 1 is buffered
    fire(0, 9, 32'h0000_0099, 1'b1);
    tick(); idle();
    fire(1, 10, 32'h0000_00AA, 1'b1);
    tick(); idle();
    check("pre_reset_ready", 64'(cdb_ready),   64'(1));
    check("pre_reset_tag",   64'(cdb_tag.num), 64'(9));
    #1 reset = 1'b0;
    #1;
    check("async_rst_ready", 64'(cdb_ready), 64'(0));
    check("async_rst_free",  64'(free),      64'(0));
    check("async_rst_tag",   64'(cdb_tag),   64'(0));
    check("async_rst_value", 64'(cdb_value), 64'(0));
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("post_rst_fu_ready",  64'(fu_ready),  64'(5'b11111));
    check("post_rst_cdb_ready", 64'(cdb_ready), 64'(0));

    repeat (2) tick();
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
